// File: rtl/fixed_divider_if.sv
// Start/done handshake and operand/result bundle for the 8.8 fixed-point divider.
interface fixed_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, num1, num2,
    input  busy, done, result, overflow, div_zero
  );

  modport slave (
    input  start, num1, num2,
    output busy, done, result, overflow, div_zero
  );
endinterface

// File: rtl/fixed_divider.sv
// Restoring divider for unsigned 8.8 fixed point: result = num1 / num2, one quotient bit per clock.
// The dividend register also collects quotient bits from its LSB as the dividend shifts out of its MSB.
module fixed_divider #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fixed_divider_if.slave  bus
);
  localparam int DW = WIDTH + FRAC;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [DW-1:0]    dq_r, dq_s;
  logic [WIDTH:0]   rem_r, rem_s;
  logic [WIDTH-1:0] divisor_r, divisor_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             overflow_r, overflow_s;
  logic             div_zero_r, div_zero_s;
  logic             busy_r, done_r;
  logic [WIDTH+1:0] trial_s;
  logic             ge_s;

  // Shifted partial remainder and the restoring compare against the divisor.
  always_comb begin
    trial_s = {rem_r, dq_r[DW-1]};
    ge_s    = (trial_s >= {2'b00, divisor_r});
  end

  // Next-state and datapath update for IDLE/CALC/DONE.
  always_comb begin
    state_s    = state_r;
    dq_s       = dq_r;
    rem_s      = rem_r;
    divisor_s  = divisor_r;
    cnt_s      = cnt_r;
    result_s   = result_r;
    overflow_s = overflow_r;
    div_zero_s = div_zero_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          divisor_s = bus.num2;
          if (bus.num2 != {WIDTH{1'b0}}) begin
            dq_s    = {bus.num1, {FRAC{1'b0}}};
            rem_s   = {(WIDTH+1){1'b0}};
            cnt_s   = CW'(DW - 1);
            state_s = CALC;
          end else begin
            result_s   = {WIDTH{1'b1}};
            overflow_s = 1'b0;
            div_zero_s = 1'b1;
            state_s    = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        rem_s = ge_s ? (WIDTH+1)'(trial_s - {2'b00, divisor_r}) : trial_s[WIDTH:0];
        dq_s  = {dq_r[DW-2:0], ge_s};
        if (cnt_r == {CW{1'b0}}) begin
          // Last quotient bit is known this cycle; register the final outputs now.
          result_s   = dq_s[WIDTH-1:0];
          overflow_s = |dq_s[DW-1:WIDTH];
          div_zero_s = 1'b0;
          state_s    = DONE;
        end else begin
          cnt_s   = cnt_r - CW'(1);
          state_s = CALC;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_r       <= {DW{1'b0}};
      rem_r      <= {(WIDTH+1){1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      dq_r       <= dq_s;
      rem_r      <= rem_s;
      divisor_r  <= divisor_s;
      cnt_r      <= cnt_s;
      result_r   <= result_s;
      overflow_r <= overflow_s;
      div_zero_r <= div_zero_s;
      busy_r     <= (state_s == CALC);
      done_r     <= (state_s == DONE);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.overflow = overflow_r;
  assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: directed cases, reset/back-to-back scenarios and random operands
// checked against a plain-arithmetic 8.8 division model.
module tb_fixed_divider;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fixed_divider_if #(.WIDTH(16)) bus ();

  fixed_divider #(.WIDTH(16), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: quotient of (num1 * 256) / num2, low 16 bits kept, overflow when it exceeds 16 bits.
  function automatic void model(input logic [15:0] n1, input logic [15:0] n2,
                                output logic [15:0] r, output logic o, output logic z);
    int unsigned q;
    if (n2 == 16'h0000) begin
      r = 16'hFFFF;
      o = 1'b0;
      z = 1'b1;
    end else begin
      q = ({16'h0000, n1} * 32'd256) / {16'h0000, n2};
      r = q[15:0];
      o = (q > 32'h0000_FFFF);
      z = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done; lat = edges after the point of call, busy_cnt = busy samples before done.
  task automatic wait_done(output bit seen, output int lat, output int busy_cnt);
    seen     = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (lat < 40) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] n1, input logic [15:0] n2);
    logic [15:0] er;
    logic        eo, ez;
    bit          seen;
    int          lat, bcnt;
    model(n1, n2, er, eo, ez);
    bus.num1  = n1;
    bus.num2  = n2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.num1  = 16'($urandom);
    bus.num2  = 16'($urandom);
    wait_done(seen, lat, bcnt);
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), (n2 == 16'h0000) ? 32'd0 : 32'd24);
    check({tag, " busy_cycles"}, 32'(bcnt), (n2 == 16'h0000) ? 32'd0 : 32'd24);
    check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(er));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(eo));
    check({tag, " div_zero"}, 32'(bus.div_zero), 32'(ez));
    tick();
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, " result_hold"}, 32'(bus.result), 32'(er));
  endtask

  initial begin
    bit          seen;
    int          lat, bcnt, done_hits, busy_hits;
    logic [15:0] n1, n2;

    tests     = 0;
    fails     = 0;
    bus.start = 1'b0;
    bus.num1  = 16'h0000;
    bus.num2  = 16'h0000;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) tick();
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst div_zero", 32'(bus.div_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op("1.5", 16'h0300, 16'h0200);
    check("1.5 value", 32'(bus.result), 32'h0180);
    run_op("third", 16'h0100, 16'h0300);
    check("third value", 32'(bus.result), 32'h0055);
    run_op("ovf", 16'h8000, 16'h0080);
    check("ovf flag", 32'(bus.overflow), 32'd1);
    check("ovf wrap", 32'(bus.result), 32'h0000);
    run_op("dz", 16'h1234, 16'h0000);
    check("dz value", 32'(bus.result), 32'hFFFF);

    // Start ignored mid-calculation, then asynchronous reset between edges.
    bus.num1  = 16'h0300;
    bus.num2  = 16'h0200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.num1  = 16'h0A00;
    bus.num2  = 16'h0500;
    tick();
    bus.start = 1'b0;
    check("calc ignore busy", 32'(bus.busy), 32'd1);
    check("calc ignore done", 32'(bus.done), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async busy", 32'(bus.busy), 32'd0);
    check("async done", 32'(bus.done), 32'd0);
    check("async result", 32'(bus.result), 32'd0);
    check("async overflow", 32'(bus.overflow), 32'd0);
    check("async div_zero", 32'(bus.div_zero), 32'd0);
    #2 rst_n = 1'b1;
    done_hits = 0;
    busy_hits = 0;
    repeat (30) begin
      tick();
      if (bus.done) done_hits++;
      if (bus.busy) busy_hits++;
    end
    check("post_rst no_done", 32'(done_hits), 32'd0);
    check("post_rst no_busy", 32'(busy_hits), 32'd0);

    // Back-to-back: start held high, second operation accepted in the DONE cycle.
    bus.num1  = 16'h0300;
    bus.num2  = 16'h0200;
    bus.start = 1'b1;
    tick();
    wait_done(seen, lat, bcnt);
    check("b2b first seen", 32'(seen), 32'd1);
    check("b2b first latency", 32'(lat), 32'd24);
    check("b2b first result", 32'(bus.result), 32'h0180);
    bus.num1 = 16'h0A00;
    bus.num2 = 16'h0500;
    tick();
    bus.start = 1'b0;
    check("b2b done drops", 32'(bus.done), 32'd0);
    check("b2b second busy", 32'(bus.busy), 32'd1);
    wait_done(seen, lat, bcnt);
    check("b2b second seen", 32'(seen), 32'd1);
    check("b2b second latency", 32'(lat), 32'd24);
    check("b2b second result", 32'(bus.result), 32'h0200);
    check("b2b second overflow", 32'(bus.overflow), 32'd0);
    tick();

    // Random operands, mixing zero and small divisors to reach div_zero and overflow.
    for (int i = 0; i < 24; i++) begin
      n1 = 16'($urandom_range(0, 65535));
      case (i % 6)
        0:       n2 = 16'h0000;
        1:       n2 = 16'($urandom_range(1, 255));
        default: n2 = 16'($urandom_range(1, 65535));
      endcase
      run_op($sformatf("rnd%0d", i), n1, n2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
